hv_cdb_receiver: RTL and testbench

- Host-facing ingress stage sitting directly upstream of hv_commandQ.
- Accepts 256-bit CDBs as 4 consecutive 64-bit beats and verifies framing and checksum.
- Buffers up to CDB_SLOTS validated CDBs and replays each one to the command queue as 4 consecutive beats (cmd_ie/cmd_in), gated by cq_cin_ready.
- Bad CDBs are dropped and reported; they never reach the queue.

---
 rtl/hv_cdb_receiver.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_hv_cdb_receiver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_cdb_receiver.sv
// hv_cdb_receiver: host-facing CDB ingress stage.
// Collects 4-beat CDBs and checks framing and checksum. Good CDBs are held in
// a small slot buffer. Each held CDB is replayed to the command queue as a
// 4-beat burst followed by one idle cycle.
module hv_cdb_receiver #(
  parameter int CMD_IO_WIDTH  = 64,
  parameter int CDB_SLOTS     = 2,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_ie,
  input  logic [CMD_IO_WIDTH-1:0]  host_in,
  output logic                     host_ready,
  input  logic                     cq_cin_ready,
  output logic                     cmd_ie,
  output logic [CMD_IO_WIDTH-1:0]  cmd_in,
  output logic                     cdb_err,
  output logic [1:0]               err_code,
  output logic [7:0]               err_tag,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int CDB_W = 4 * CMD_IO_WIDTH;
  localparam int PTR_W = (CDB_SLOTS > 1) ? $clog2(CDB_SLOTS) : 1;
  localparam int OCC_W = $clog2(CDB_SLOTS + 1);
  localparam int SUM_W = OCC_W + 1;

  localparam logic [1:0] ERR_SUM   = 2'b01;
  localparam logic [1:0] ERR_FRAME = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

  // Word 4 carries, per byte lane, the XOR of the other seven 32-bit words.
  function automatic logic cdb_sum_ok(input logic [255:0] cdb);
    logic [31:0] sum;
    sum = cdb[31:0] ^ cdb[63:32] ^ cdb[95:64] ^ cdb[127:96]
        ^ cdb[191:160] ^ cdb[223:192] ^ cdb[255:224];
    return (sum == cdb[159:128]);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(CDB_SLOTS - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Beat collection
  logic [1:0]              rx_cnt_r;
  logic [CMD_IO_WIDTH-1:0] rx_lane0_r;
  logic [CMD_IO_WIDTH-1:0] rx_lane1_r;
  logic [CMD_IO_WIDTH-1:0] rx_lane2_r;
  logic                    rx_ovf_r;

  // CHECK stage and slot buffer
  logic                    chk_valid_r;
  logic [CDB_W-1:0]        chk_data_r;
  logic [CDB_W-1:0]        slot_mem_r [CDB_SLOTS];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [OCC_W-1:0]        occ_r;
  logic                    host_ready_r;

  // Replay FSM
  tx_state_t               tx_state_r;
  logic [1:0]              tx_idx_r;
  logic                    cmd_ie_r;
  logic [CMD_IO_WIDTH-1:0] cmd_in_r;

  // Error reporting
  logic                     cdb_err_r;
  logic [1:0]               err_code_r;
  logic [7:0]               err_tag_r;
  logic [ERR_CNT_WIDTH-1:0] err_count_r;

  logic [CDB_W-1:0]        rx_cdb_s;
  logic                    rx_last_s;
  logic                    rx_frame_err_s;
  logic                    rx_sum_ok_s;
  logic                    rx_good_s;
  logic                    slot_wr_s;
  logic                    slot_rd_s;
  logic                    tx_start_s;
  logic [OCC_W-1:0]        occ_nxt_s;
  logic                    host_ready_nxt_s;
  logic [CDB_W-1:0]        tx_slot_s;
  logic [CMD_IO_WIDTH-1:0] tx_beat_s;
  logic                    err_evt_s;
  logic [1:0]              err_code_nxt_s;
  logic [7:0]              err_tag_nxt_s;

  assign rx_cdb_s       = {host_in, rx_lane2_r, rx_lane1_r, rx_lane0_r};
  assign rx_last_s      = host_ie && (rx_cnt_r == 2'd3);
  assign rx_frame_err_s = !host_ie && (rx_cnt_r != 2'd0);
  assign rx_sum_ok_s    = cdb_sum_ok(rx_cdb_s);
  assign rx_good_s      = rx_last_s && !rx_ovf_r && rx_sum_ok_s;
  assign slot_wr_s      = chk_valid_r;
  assign slot_rd_s      = (tx_state_r == TX_SEND) && (tx_idx_r == 2'd3);
  assign tx_start_s     = (tx_state_r == TX_IDLE) && (occ_r != {OCC_W{1'b0}}) && cq_cin_ready;

  // Next occupancy: a write and a free in the same cycle cancel out
  always_comb begin
    occ_nxt_s = occ_r;
    if (slot_wr_s && !slot_rd_s) begin
      occ_nxt_s = occ_r + OCC_W'(1);
    end else if (!slot_wr_s && slot_rd_s) begin
      occ_nxt_s = occ_r - OCC_W'(1);
    end else begin
      occ_nxt_s = occ_r;
    end
  end

  // A CDB sitting in CHECK has a slot reserved, so count it as occupied
  always_comb begin
    host_ready_nxt_s = (SUM_W'(occ_nxt_s) + SUM_W'(rx_good_s)) < SUM_W'(CDB_SLOTS);
  end

  // Select the outgoing beat of the slot at the read pointer
  always_comb begin
    tx_slot_s = slot_mem_r[rd_ptr_r];
    case (tx_idx_r)
      2'd0:    tx_beat_s = tx_slot_s[CMD_IO_WIDTH-1:0];
      2'd1:    tx_beat_s = tx_slot_s[2*CMD_IO_WIDTH-1:CMD_IO_WIDTH];
      2'd2:    tx_beat_s = tx_slot_s[3*CMD_IO_WIDTH-1:2*CMD_IO_WIDTH];
      default: tx_beat_s = tx_slot_s[4*CMD_IO_WIDTH-1:3*CMD_IO_WIDTH];
    endcase
  end

  // Classify this cycle's error, if any; framing and end-of-CDB never coincide
  always_comb begin
    err_evt_s      = 1'b0;
    err_code_nxt_s = 2'b00;
    err_tag_nxt_s  = 8'h00;
    if (rx_frame_err_s) begin
      err_evt_s      = 1'b1;
      err_code_nxt_s = ERR_FRAME;
      if (rx_cnt_r >= 2'd2) begin
        err_tag_nxt_s = rx_lane0_r[15:8];
      end else begin
        err_tag_nxt_s = 8'h00;
      end
    end else if (rx_last_s && rx_ovf_r) begin
      err_evt_s      = 1'b1;
      err_code_nxt_s = ERR_OVF;
      err_tag_nxt_s  = rx_lane0_r[15:8];
    end else if (rx_last_s && !rx_sum_ok_s) begin
      err_evt_s      = 1'b1;
      err_code_nxt_s = ERR_SUM;
      err_tag_nxt_s  = rx_lane0_r[15:8];
    end else begin
      err_evt_s      = 1'b0;
      err_code_nxt_s = 2'b00;
      err_tag_nxt_s  = 8'h00;
    end
  end

  // Collect host beats into lanes; beat 3 bypasses straight into CHECK
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt_r   <= 2'd0;
      rx_lane0_r <= {CMD_IO_WIDTH{1'b0}};
      rx_lane1_r <= {CMD_IO_WIDTH{1'b0}};
      rx_lane2_r <= {CMD_IO_WIDTH{1'b0}};
      rx_ovf_r   <= 1'b0;
    end else if (host_ie) begin
      rx_cnt_r <= rx_cnt_r + 2'd1;
      case (rx_cnt_r)
        2'd0: begin
          rx_lane0_r <= host_in;
          rx_ovf_r   <= ~host_ready_r;
        end
        2'd1:    rx_lane1_r <= host_in;
        2'd2:    rx_lane2_r <= host_in;
        default: rx_lane2_r <= rx_lane2_r;
      endcase
    end else begin
      rx_cnt_r <= 2'd0;
      rx_ovf_r <= 1'b0;
    end
  end

  // CHECK stage, slot writes/frees, pointers and host_ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_valid_r  <= 1'b0;
      chk_data_r   <= {CDB_W{1'b0}};
      for (int i = 0; i < CDB_SLOTS; i++) begin
        slot_mem_r[i] <= {CDB_W{1'b0}};
      end
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      occ_r        <= {OCC_W{1'b0}};
      host_ready_r <= 1'b1;
    end else begin
      chk_valid_r <= rx_good_s;
      if (rx_good_s) begin
        chk_data_r <= rx_cdb_s;
      end
      if (slot_wr_s) begin
        slot_mem_r[wr_ptr_r] <= chk_data_r;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      if (slot_rd_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      occ_r        <= occ_nxt_s;
      host_ready_r <= host_ready_nxt_s;
    end
  end

  // Replay FSM: 4 unconditional beats once started, then one idle cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_r <= TX_IDLE;
      tx_idx_r   <= 2'd0;
      cmd_ie_r   <= 1'b0;
      cmd_in_r   <= {CMD_IO_WIDTH{1'b0}};
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          if (tx_start_s) begin
            cmd_ie_r   <= 1'b1;
            cmd_in_r   <= tx_beat_s;
            tx_idx_r   <= 2'd1;
            tx_state_r <= TX_SEND;
          end else begin
            cmd_ie_r <= 1'b0;
          end
        end
        TX_SEND: begin
          cmd_ie_r <= 1'b1;
          cmd_in_r <= tx_beat_s;
          tx_idx_r <= tx_idx_r + 2'd1;
          if (tx_idx_r == 2'd3) begin
            tx_state_r <= TX_GAP;
          end
        end
        TX_GAP: begin
          cmd_ie_r   <= 1'b0;
          tx_state_r <= TX_IDLE;
        end
        default: begin
          cmd_ie_r   <= 1'b0;
          tx_idx_r   <= 2'd0;
          tx_state_r <= TX_IDLE;
        end
      endcase
    end
  end

  // Error pulse, held code/tag and saturating error count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_err_r   <= 1'b0;
      err_code_r  <= 2'b00;
      err_tag_r   <= 8'h00;
      err_count_r <= {ERR_CNT_WIDTH{1'b0}};
    end else begin
      cdb_err_r <= err_evt_s;
      if (err_evt_s) begin
        err_code_r <= err_code_nxt_s;
        err_tag_r  <= err_tag_nxt_s;
        if (err_count_r != {ERR_CNT_WIDTH{1'b1}}) begin
          err_count_r <= err_count_r + ERR_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign host_ready = host_ready_r;
  assign cmd_ie     = cmd_ie_r;
  assign cmd_in     = cmd_in_r;
  assign cdb_err    = cdb_err_r;
  assign err_code   = err_code_r;
  assign err_tag    = err_tag_r;
  assign err_count  = err_count_r;

endmodule

// File: tb/tb_hv_cdb_receiver.sv
// Testbench for hv_cdb_receiver: directed CDBs, with a scoreboard of expected
// command-queue beats and error reports that is checked by a separate monitor.
`timescale 1ns/1ps
module tb_hv_cdb_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_ie = 1'b0;
  logic [63:0] host_in = 64'd0;
  logic        cq_cin_ready = 1'b0;

  logic        host_ready, cmd_ie, cdb_err;
  logic [63:0] cmd_in;
  logic [1:0]  err_code;
  logic [7:0]  err_tag;
  logic [15:0] err_count;

  // Second instance with a narrow counter so that saturation is reachable quickly
  logic        sat_host_ready, sat_cmd_ie, sat_cdb_err;
  logic [63:0] sat_cmd_in;
  logic [1:0]  sat_err_code;
  logic [7:0]  sat_err_tag;
  logic [3:0]  sat_err_count;

  hv_cdb_receiver u_dut (
    .clk(clk), .reset(reset), .host_ie(host_ie), .host_in(host_in),
    .host_ready(host_ready), .cq_cin_ready(cq_cin_ready),
    .cmd_ie(cmd_ie), .cmd_in(cmd_in), .cdb_err(cdb_err),
    .err_code(err_code), .err_tag(err_tag), .err_count(err_count)
  );

  hv_cdb_receiver #(.ERR_CNT_WIDTH(4)) u_sat (
    .clk(clk), .reset(reset), .host_ie(host_ie), .host_in(host_in),
    .host_ready(sat_host_ready), .cq_cin_ready(cq_cin_ready),
    .cmd_ie(sat_cmd_ie), .cmd_in(sat_cmd_in), .cdb_err(sat_cdb_err),
    .err_code(sat_err_code), .err_tag(sat_err_tag), .err_count(sat_err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  code;
    logic [7:0]  tag;
    logic [15:0] cnt;
  } err_t;

  logic [63:0] exp_beats [$];
  err_t        exp_errs [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          err_n = 0;
  logic [63:0] mon_beat;
  err_t        mon_err;
  logic        found;
  logic [9:0]  pat;
  logic [255:0] bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Hand-laid CDB: op 0x40 and tag in bytes 0/1, checksum word 4 = {tag, 0x40}
  function automatic logic [255:0] mk(input logic [7:0] tag);
    logic [255:0] c;
    c = 256'd0;
    c[7:0]     = 8'h40;
    c[15:8]    = tag;
    c[135:128] = 8'h40;
    c[143:136] = tag;
    return c;
  endfunction

  task automatic send_beats(input logic [255:0] c, input int nb, input bit fwd);
    if (fwd) begin
      for (int i = 0; i < 4; i++) exp_beats.push_back(c[64*i +: 64]);
    end
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      host_ie = 1'b1;
      host_in = c[64*i +: 64];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      host_ie = 1'b0;
      host_in = 64'd0;
    end
  endtask

  task automatic push_err(input logic [1:0] code, input logic [7:0] tag);
    err_t e;
    err_n++;
    e.code = code;
    e.tag  = tag;
    e.cnt  = 16'(err_n);
    exp_errs.push_back(e);
  endtask

  // Monitor: every presented beat or error pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (cmd_ie) begin
        if (exp_beats.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h, expected no beat", cmd_in);
        end else begin
          mon_beat = exp_beats.pop_front();
          check("cmd_beat", cmd_in, mon_beat);
        end
      end
      if (cdb_err) begin
        if (exp_errs.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_err: got code %b tag %h, expected no error", err_code, err_tag);
        end else begin
          mon_err = exp_errs.pop_front();
          check("err_code", 64'(err_code), 64'(mon_err.code));
          check("err_tag", 64'(err_tag), 64'(mon_err.tag));
          check("err_count", 64'(err_count), 64'(mon_err.cnt));
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Asynchronous reset before any clock edge
    #1 reset = 1'b0;
    #1;
    check("rst_host_ready", 64'(host_ready), 64'd1);
    check("rst_cmd_ie", 64'(cmd_ie), 64'd0);
    check("rst_cmd_in", cmd_in, 64'd0);
    check("rst_cdb_err", 64'(cdb_err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_err_tag", 64'(err_tag), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cq_cin_ready = 1'b1;
    idle(2);

    // Test 1: three valid CDBs, first-beat latency of 2 cycles after beat 3
    send_beats(mk(8'h00), 4, 1'b1);
    @(posedge clk); #1;
    host_ie = 1'b0;
    check("lat_e0_idle", 64'(cmd_ie), 64'd0);
    @(posedge clk); #1;
    check("lat_e1_idle", 64'(cmd_ie), 64'd0);
    @(posedge clk); #1;
    check("lat_e2_valid", 64'(cmd_ie), 64'd1);
    check("lat_e2_beat0", cmd_in, 64'h0000_0000_0000_0040);
    send_beats(mk(8'h01), 4, 1'b1);
    send_beats(mk(8'h02), 4, 1'b1);
    idle(20);

    // Test 2: valid tag 5, then the same CDB with bit 128 flipped
    send_beats(mk(8'h05), 4, 1'b1);
    idle(1);
    bad = mk(8'h05);
    bad[128] = ~bad[128];
    push_err(2'b01, 8'h05);
    send_beats(bad, 4, 1'b0);
    idle(20);

    // Test 3: framing errors after 1 beat (tag 0) and after 2 beats (tag 7)
    push_err(2'b10, 8'h00);
    send_beats(mk(8'h07), 1, 1'b0);
    idle(3);
    push_err(2'b10, 8'h07);
    send_beats(mk(8'h07), 2, 1'b0);
    idle(1);
    check("frame_no_pulse_yet", 64'(cdb_err), 64'd0);
    @(posedge clk); #1;
    check("frame_pulse", 64'(cdb_err), 64'd1);
    idle(2);
    send_beats(mk(8'h08), 4, 1'b1);
    idle(15);

    // Test 4: backpressure fills both slots, third CDB overflows
    cq_cin_ready = 1'b0;
    send_beats(mk(8'h09), 4, 1'b1);
    idle(1);
    send_beats(mk(8'h0A), 4, 1'b1);
    idle(2);
    check("full_host_ready", 64'(host_ready), 64'd0);
    push_err(2'b11, 8'h0B);
    send_beats(mk(8'h0B), 4, 1'b0);
    idle(3);
    check("ovf_no_beats", 64'(cmd_ie), 64'd0);
    cq_cin_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cmd_ie) found = 1'b1;
    end
    check("burst_seen", 64'(found), 64'd1);
    pat = 10'd1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pat = {pat[8:0], cmd_ie};
    end
    check("burst_gap_pattern", 64'(pat), 64'(10'b1111011110));
    idle(3);
    check("drained_host_ready", 64'(host_ready), 64'd1);
    idle(5);

    // Test 5: reset during SEND beat 1
    send_beats(mk(8'h0C), 4, 1'b1);
    @(posedge clk); #1;
    host_ie = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_sending", 64'(cmd_ie), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_cmd_ie", 64'(cmd_ie), 64'd0);
    check("mid_rst_host_ready", 64'(host_ready), 64'd1);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    check("mid_rst_sat_count", 64'(sat_err_count), 64'd0);
    exp_beats.delete();
    err_n = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(15);
    check("post_rst_no_beats", 64'(exp_beats.size()), 64'd0);

    // Test 6: a run of checksum errors, narrow counter saturates at 0xF
    bad = mk(8'h20);
    bad[128] = ~bad[128];
    for (int i = 0; i < 17; i++) begin
      push_err(2'b01, 8'h20);
      send_beats(bad, 4, 1'b0);
    end
    idle(5);
    check("sum_run_count", 64'(err_count), 64'd17);
    check("sat_count", 64'(sat_err_count), 64'hF);

    idle(5);
    check("beats_all_seen", 64'(exp_beats.size()), 64'd0);
    check("errs_all_seen", 64'(exp_errs.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
